rout_uart_reporter: RTL and testbench

- Downstream consumer of the processor's 16-bit result output `rout`.
- Watches `rout` and, on each change, serialises the value as a 6-byte ASCII line on a UART TX pin (8N1): 4 uppercase hex digits MSB-first, then CR, then LF.
- Gives the board a host-visible trace of program results without a logic analyser.
- Sits at top level beside the processor core, fed directly by `rout`.

---
 rtl/kgp_io_pkg.sv | 35 +++
 rtl/uart_tx_byte.sv | 80 ++++++++
 rtl/rout_uart_reporter.sv | 94 +++++++++
 tb/tb_rout_uart_reporter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_io_pkg.sv
// Shared types and helpers for the result reporter: UART FSM states, ASCII
// constants and the byte-select function for the "HHHH\r\n" line.
package kgp_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         FRAME_BYTES = 6;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Byte idx of the report line for value val, MSB nibble first.
    function automatic logic [7:0] frame_byte(input logic [15:0] val, input logic [2:0] idx);
        case (idx)
            3'd0:    return hex2ascii(val[15:12]);
            3'd1:    return hex2ascii(val[11:8]);
            3'd2:    return hex2ascii(val[7:4]);
            3'd3:    return hex2ascii(val[3:0]);
            3'd4:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: byte accepted on byte_vld & byte_rdy, tx falls at the next edge.
// byte_rdy is high in IDLE and on the last cycle of STOP, so a waiting byte follows with no gap.
module uart_tx_byte
    import kgp_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_vld,
    input  logic [7:0] byte_dat,
    output logic       byte_rdy,
    output logic       tx
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end  = (bit_cnt == CNT_LAST);
    assign byte_rdy = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            bit_cnt <= ((state == ST_IDLE) || bit_end) ? '0 : bit_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (byte_vld) begin
                        shreg <= byte_dat;
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (byte_vld) begin
                            shreg <= byte_dat;
                            tx    <= 1'b0;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rout_uart_reporter.sv
// Reports each change of rout as "HHHH\r\n" on an 8N1 UART; change-to-start-bit is 2 edges after rout_q.
// A single pending slot absorbs changes during a frame or while en is low; overwrites count in drop_cnt.
module rout_uart_reporter
    import kgp_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DROP_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       rout,
    input  logic              en,
    output logic              tx,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    logic [15:0] rout_q;
    logic [15:0] last_val;
    logic [15:0] pending;
    logic [15:0] snap;
    logic        pending_valid;
    logic        first;
    logic [2:0]  char_idx;
    logic        upd;
    logic        start_go;
    logic        consume;
    logic        byte_vld;
    logic        byte_rdy;
    logic [7:0]  byte_dat;

    always_ff @(posedge clk) begin
        rout_q <= rout;
    end

    assign upd      = (rout_q != last_val) || first;
    assign start_go = !busy && pending_valid && en;
    assign consume  = start_go && byte_rdy;

    // The first byte comes straight from pending because snap loads on the same edge.
    assign byte_vld = start_go || (busy && (char_idx != LAST_IDX));
    assign byte_dat = start_go ? frame_byte(pending, 3'd0) : frame_byte(snap, char_idx + 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            first         <= 1'b1;
            last_val      <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            snap          <= '0;
            char_idx      <= '0;
            busy          <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            if (upd) begin
                pending       <= rout_q;
                pending_valid <= 1'b1;
                last_val      <= rout_q;
                first         <= 1'b0;
                if (pending_valid && !consume && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end else if (consume) begin
                pending_valid <= 1'b0;
            end

            if (consume) begin
                snap     <= pending;
                char_idx <= '0;
                busy     <= 1'b1;
            end else if (busy && byte_rdy) begin
                if (char_idx == LAST_IDX) begin
                    busy <= 1'b0;
                end else begin
                    char_idx <= char_idx + 3'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .byte_vld (byte_vld),
        .byte_dat (byte_dat),
        .byte_rdy (byte_rdy),
        .tx       (tx)
    );

endmodule

// File: tb/tb_rout_uart_reporter.sv
// Bench for rout_uart_reporter: a UART receiver decodes tx, and frames are checked against
// constant tables, directed corner cases and a conservation model over random rout traffic.
module tb_rout_uart_reporter;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          clk;
    logic          reset;
    logic          en;
    logic [15:0]   rout;
    logic          tx;
    logic          busy;
    logic [DW-1:0] drop_cnt;

    rout_uart_reporter #(.CLKS_PER_BIT(CPB), .DROP_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .rout     (rout),
        .en       (en),
        .tx       (tx),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // UART receiver: samples every cycle on the falling edge, checks each bit is flat for CPB cycles.
    int         cyc        = 0;
    int         rx_glitch  = 0;
    int         rx_framing = 0;
    bit         rx_active  = 0;
    int         rx_cnt     = 0;
    int         rx_start   = 0;
    logic       rx_bit;
    logic [7:0] rx_shift;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    always @(negedge clk) begin
        cyc++;
        if (reset === 1'b1) begin
            rx_active = 0;
        end else begin
            if (!rx_active && tx === 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
                rx_start  = cyc;
            end
            if (rx_active) begin
                if (rx_cnt % CPB == 0) rx_bit = tx;
                else if (tx !== rx_bit) rx_glitch++;
                if (rx_cnt % CPB == 0 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
                    rx_shift[rx_cnt / CPB - 1] = tx;
                if (rx_cnt == 9 * CPB && tx !== 1'b1) rx_framing++;
                if (rx_cnt == 10 * CPB - 1) begin
                    rx_q.push_back(rx_shift);
                    rx_t.push_back(rx_start);
                    rx_active = 0;
                end else begin
                    rx_cnt++;
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        rx_q.delete();
        rx_t.delete();
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk);
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_tx_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx === 1'b0) break;
        end
    endtask

    task automatic wait_idle(input int budget);
        int quiet;
        quiet = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 20) break;
        end
    endtask

    task automatic pop_frame(output logic [47:0] f, output int t0);
        f  = '0;
        t0 = rx_t[0];
        for (int k = 0; k < 6; k++) begin
            f = {f[39:0], rx_q.pop_front()};
            void'(rx_t.pop_front());
        end
    endtask

    task automatic expect_frame(input string name, input logic [47:0] exp, input int budget,
                                output int t0);
        bit          ok;
        logic [47:0] f;
        t0 = -1;
        wait_bytes(6, budget, ok);
        if (!ok) begin
            chk({name, "_timeout"}, rx_q.size(), 6);
        end else begin
            pop_frame(f, t0);
            chk(name, f, exp);
        end
    endtask

    function automatic bit dec_frame(input logic [47:0] f, output logic [15:0] v);
        bit ok;
        ok = (f[15:0] == 16'h0D0A);
        v  = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] c;
            logic [3:0] n;
            c = f[47 - 8 * i -: 8];
            if (c >= 8'h30 && c <= 8'h39) n = 4'(c - 8'h30);
            else if (c >= 8'h41 && c <= 8'h46) n = 4'(c - 8'h37);
            else begin
                n  = 4'h0;
                ok = 0;
            end
            v = {v[11:0], n};
        end
        return ok;
    endfunction

    typedef struct {
        logic [15:0] val;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n, c0, t0, frames, nerr, idx;
        logic [47:0] f;
        logic [15:0] v, last_v;
        logic [15:0] vals[$];

        vecs[0] = '{16'hFFFF, 48'h4646_4646_0D0A};
        vecs[1] = '{16'h9C05, 48'h3943_3035_0D0A};
        vecs[2] = '{16'h7E3B, 48'h3745_3342_0D0A};
        vecs[3] = '{16'h0000, 48'h3030_3030_0D0A};
        vecs[4] = '{16'h8D61, 48'h3844_3631_0D0A};

        reset = 1'b1;
        en    = 1'b1;
        rout  = 16'h1A2F;

        // Reset release with a held value: start bit two edges later, 240 busy cycles.
        do_reset(3);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        @(negedge clk);
        chk("t1_tx_idle_before_start", tx, 1'b1);
        @(negedge clk);
        chk("t1_tx_start", tx, 1'b0);
        chk("t1_busy_start", busy, 1'b1);
        n = 1;
        for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        chk("t1_busy_len", n, 60 * CPB);
        expect_frame("t1_frame", 48'h3141_3246_0D0A, 100, t0);

        // Zero held through reset is reported exactly once.
        rout = 16'h0000;
        do_reset(3);
        expect_frame("t2_frame", 48'h3030_3030_0D0A, 400, t0);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        chk("t2_quiet_tx", n, 0);
        chk("t2_no_more_bytes", rx_q.size(), 0);

        // Single changes from idle: frame content and change-to-start latency.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rout = vecs[i].val;
            c0   = cyc;
            expect_frame($sformatf("vec%0d_frame", i), vecs[i].exp, 400, t0);
            chk($sformatf("vec%0d_latency", i), t0, c0 + 4);
            repeat (4) @(posedge clk);
        end
        chk("vec_drop", drop_cnt, 0);

        // Mid-frame changes: snapshot stays, last pending value wins, one drop.
        @(posedge clk); #1 rout = 16'h0001;
        wait_tx_low(50);
        chk("ow_frame_started", tx, 1'b0);
        repeat (20) @(posedge clk);
        #1 rout = 16'h0002;
        repeat (20) @(posedge clk);
        #1 rout = 16'h0003;
        expect_frame("ow_frame1", 48'h3030_3031_0D0A, 400, t0);
        expect_frame("ow_frame2", 48'h3030_3033_0D0A, 400, t0);
        chk("ow_drop", drop_cnt, 1);

        // en low holds the pending value; raising en starts one edge later.
        repeat (4) @(posedge clk);
        #1;
        en   = 1'b0;
        rout = 16'hBEEF;
        n    = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        chk("en_low_quiet", n, 0);
        chk("en_low_drop", drop_cnt, 1);
        @(posedge clk); #1;
        en = 1'b1;
        c0 = cyc;
        expect_frame("en_frame", 48'h4245_4546_0D0A, 400, t0);
        chk("en_latency", t0, c0 + 2);

        // 300 back-to-back changes: counter saturates, final value still reported.
        repeat (4) @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            rout = 16'h4000 + 16'(i);
        end
        repeat (2) @(negedge clk);
        chk("sat_drop", drop_cnt, 8'hFF);
        wait_idle(3000);
        chk("sat_idle", busy, 1'b0);
        frames = 0;
        f      = '0;
        while (rx_q.size() >= 6) begin
            pop_frame(f, t0);
            frames++;
        end
        chk("sat_frames", frames, 3);
        chk("sat_last_frame", f, 48'h3431_3242_0D0A);

        // Reset about 100 cycles into a frame abandons it; the value is re-sent whole.
        @(posedge clk); #1 rout = 16'h5A5A;
        wait_tx_low(50);
        chk("rm_frame_started", tx, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        chk("rm_busy_before", busy, 1'b1);
        reset = 1'b1;
        rx_q.delete();
        rx_t.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rm_tx_at_reset", tx, 1'b1);
        chk("rm_busy_at_reset", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        c0    = cyc;
        expect_frame("rm_frame", 48'h3541_3541_0D0A, 400, t0);
        chk("rm_latency", t0, c0 + 3);

        // Random traffic: every update is either framed or counted as dropped, in order.
        rout = 16'($urandom);
        do_reset(2);
        vals.delete();
        vals.push_back(rout);
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 300)) @(posedge clk);
            #1;
            do v = 16'($urandom); while (v == rout);
            rout = v;
            vals.push_back(v);
            en = ($urandom_range(0, 4) != 0);
        end
        @(posedge clk); #1 en = 1'b1;
        wait_idle(3000);
        chk("rand_idle", busy, 1'b0);
        chk("rand_whole_frames", rx_q.size() % 6, 0);
        frames = 0;
        nerr   = 0;
        idx    = 0;
        last_v = '0;
        while (rx_q.size() >= 6) begin
            pop_frame(f, t0);
            frames++;
            if (!dec_frame(f, v)) begin
                nerr++;
            end else begin
                while (idx < vals.size() && vals[idx] != v) idx++;
                if (idx >= vals.size()) nerr++;
                else idx++;
            end
            last_v = v;
        end
        chk("rand_order", nerr, 0);
        chk("rand_conservation", frames + int'(drop_cnt), vals.size());
        chk("rand_last_value", last_v, vals[vals.size() - 1]);

        chk("rx_bit_timing", rx_glitch, 0);
        chk("rx_stop_bits", rx_framing, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
